matrix_scan_ctrl: RTL and testbench
===================================

// Module: matrix_scan_ctrl
// PURPOSE
//   Column-refresh controller for the 5x7 LED matrix display.
//   - Holds a double-buffered 35-bit frame.
//   - Steps a column index 0..NUM_COLS-1 at a programmable rate, with blanking between columns.
//   - Drives the column-select decoder (col_sel/col_en) and the active-low row lines.
//   - Sits directly upstream of the column decoder.
// PARAMETERS
//   CLK_DIV       50000  clk cycles a column stays lit (>=2)
//   BLANK_CYCLES  16     clk cycles all LEDs are off between columns (>=1)
//   NUM_COLS      5      columns per frame (col_sel wraps NUM_COLS-1 -> 0)
//   NUM_ROWS      7      rows per column
// PORTS
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   synchronous reset, active-low
//   run         in   1   1 = scanning, 0 = display off
//   frame_load  in   1   one-cycle strobe: frame_data valid
//   frame_data  in   35  pixel bits, bit [c*7+r] = column c row r, 1 = lit
//   frame_ready out  1   1 = a frame_load is accepted this cycle
//   frame_done  out  1   one-cycle pulse when a new frame becomes active
//   col_sel     out  3   column index to decoder
//   col_en      out  1   decoder enable, 1 = selected column driven
//   row_data    out  7   row lines, active-low (0 = LED on)
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge):
//   - Outputs: col_sel=0, col_en=0, row_data=7'h7F, frame_done=0, frame_ready=1.
//   - Internal: active and shadow buffers = 0, pending=0, state=IDLE, counters=0.
//   States:
//   - IDLE:  col_en=0, row_data=7'h7F, col_sel=0.
//            run=1 -> BLANK (col_sel stays 0).
//   - BLANK: col_en=0, row_data=7'h7F. Count BLANK_CYCLES cycles, then -> SCAN.
//            On that transition: col_en<=1, row_data<=~active[col_sel*7 +: 7].
//   - SCAN:  col_en=1. Count CLK_DIV cycles, then -> BLANK.
//            On that transition: col_en<=0, row_data<=7'h7F, col_sel<=col_sel+1, wrapping NUM_COLS-1 -> 0.
//   - Any state: run=0 -> IDLE next cycle. Counters clear, col_sel<=0, col_en<=0. Buffers retained.
//   Column timing:
//   - Each column is lit exactly CLK_DIV cycles.
//   - Gap between columns is exactly BLANK_CYCLES cycles.
//   - Frame period = NUM_COLS*(CLK_DIV+BLANK_CYCLES).
//   Frame load:
//   - frame_ready = ~pending (combinational).
//   - frame_load & frame_ready:
//     - In IDLE: active<=frame_data, frame_done pulses next cycle, pending stays 0.
//     - Otherwise: shadow<=frame_data, pending<=1.
//   - frame_load & ~frame_ready: ignored, no state change.
//   Frame swap:
//   - Occurs on the SCAN->BLANK transition where col_sel wraps to 0, if pending=1.
//   - Effect: active<=shadow, pending<=0, frame_done=1 for one cycle.
//   - A frame is never swapped mid-frame, so no tearing.
//   - A load and a swap never coincide: pending=1 blocks the load.
//   - Swap is suppressed if run drops on the same edge; the pending frame swaps at the next wrap.
//   Other rules:
//   - row_data changes only while col_en=0 or on the BLANK->SCAN edge, never mid-column.
//   - col_sel never exceeds NUM_COLS-1.
//   - Counter widths: $clog2 of CLK_DIV and BLANK_CYCLES.
// TESTING  (CLK_DIV=4, BLANK_CYCLES=2)
//   1. Reset mid-SCAN (rst_n=0 one edge) -> next cycle col_sel=0, col_en=0, row_data=7F, frame_ready=1.
//   2. IDLE, load 35'h1 (col0 row0), then run=1 -> frame_done pulses once; after 2 blank cycles col_en=1, col_sel=0, row_data=7E for exactly 4 cycles.
//   3. Free-run one frame -> col_sel sequence 0,1,2,3,4,0; each col_en high for 4 and low for 2; period 30 cycles.
//   4. Load during col2 -> frame_ready=0 next cycle; a second load is ignored; swap and frame_done occur at the 4->0 wrap; the new col0 pattern appears.
//   5. run=0 during SCAN of col3 -> next cycle IDLE, col_en=0, col_sel=0; run=1 restarts at col0 after 2 blank cycles.
//   6. frame_data all ones -> row_data=00 in every lit column, 7F in every blank slot.

Source files
------------

// File: rtl/matrix_scan_ctrl.sv
// rtl/matrix_scan_ctrl.sv - column-refresh controller for a 5x7 LED matrix
// Double-buffered frame, blanked column stepping, decoder select and active-low rows.

module matrix_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int NUM_COLS     = 5,
  parameter int NUM_ROWS     = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic                         frame_load,
  input  logic [NUM_COLS*NUM_ROWS-1:0] frame_data,
  output logic                         frame_ready,
  output logic                         frame_done,
  output logic [2:0]                   col_sel,
  output logic                         col_en,
  output logic [NUM_ROWS-1:0]          row_data
);

  localparam int FW = NUM_COLS * NUM_ROWS;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    COL_LAST   = 3'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SCAN  = 2'd2
  } state_e;

  state_e                state_q;
  logic [DW-1:0]         div_cnt_q;
  logic [BW-1:0]         blank_cnt_q;
  logic [2:0]            col_sel_q;
  logic                  col_en_q;
  logic [NUM_ROWS-1:0]   row_data_q;
  logic                  frame_done_q;
  logic [FW-1:0]         active_q;
  logic [FW-1:0]         shadow_q;
  logic                  pending_q;

  logic [2:0]            col_next_d;
  logic [NUM_ROWS-1:0]   col_rows_d;
  logic                  load_ok_d;

  assign col_next_d = (col_sel_q == COL_LAST) ? 3'd0 : col_sel_q + 3'd1;
  assign load_ok_d  = frame_load & ~pending_q;

  always_comb begin
    col_rows_d = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_sel_q == 3'(c)) begin
        col_rows_d = active_q[c*NUM_ROWS +: NUM_ROWS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      blank_cnt_q  <= '0;
      col_sel_q    <= '0;
      col_en_q     <= 1'b0;
      row_data_q   <= '1;
      frame_done_q <= 1'b0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      // Dropping run wins over every in-progress transition, including a pending swap.
      if (!run) begin
        state_q     <= IDLE;
        div_cnt_q   <= '0;
        blank_cnt_q <= '0;
        col_sel_q   <= '0;
        col_en_q    <= 1'b0;
        row_data_q  <= '1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q     <= BLANK;
            blank_cnt_q <= '0;
            col_en_q    <= 1'b0;
            row_data_q  <= '1;
          end
          BLANK: begin
            if (blank_cnt_q == BLANK_LAST) begin
              state_q     <= SCAN;
              blank_cnt_q <= '0;
              div_cnt_q   <= '0;
              col_en_q    <= 1'b1;
              row_data_q  <= ~col_rows_d;
            end else begin
              blank_cnt_q <= blank_cnt_q + 1'b1;
            end
          end
          SCAN: begin
            if (div_cnt_q == DIV_LAST) begin
              state_q     <= BLANK;
              div_cnt_q   <= '0;
              blank_cnt_q <= '0;
              col_en_q    <= 1'b0;
              row_data_q  <= '1;
              col_sel_q   <= col_next_d;
              if (col_sel_q == COL_LAST && pending_q) begin
                active_q     <= shadow_q;
                pending_q    <= 1'b0;
                frame_done_q <= 1'b1;
              end
            end else begin
              div_cnt_q <= div_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end

      // Loads only happen with pending clear, so they never collide with a swap.
      if (load_ok_d) begin
        if (state_q == IDLE) begin
          active_q     <= frame_data;
          frame_done_q <= 1'b1;
        end else begin
          shadow_q  <= frame_data;
          pending_q <= 1'b1;
        end
      end
    end
  end

  assign frame_ready = ~pending_q;
  assign frame_done  = frame_done_q;
  assign col_sel     = col_sel_q;
  assign col_en      = col_en_q;
  assign row_data    = row_data_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb/tb_matrix_scan_ctrl.sv - scoreboard bench for matrix_scan_ctrl
module tb_matrix_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int BLANK   = 2;
  localparam int NC      = 5;
  localparam int NR      = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        frame_load = 1'b0;
  logic [34:0] frame_data = '0;
  logic        frame_ready;
  logic        frame_done;
  logic [2:0]  col_sel;
  logic        col_en;
  logic [6:0]  row_data;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK), .NUM_COLS(NC), .NUM_ROWS(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .frame_load(frame_load),
    .frame_data(frame_data), .frame_ready(frame_ready), .frame_done(frame_done),
    .col_sel(col_sel), .col_en(col_en), .row_data(row_data)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    int         col;
    logic [6:0] rows;
    int         len;
    int         gap;
  } col_exp_t;

  col_exp_t exp_q[$];
  int       rise0_q[$];
  int       cols_done = 0;
  int       done_cnt = 0;
  int       done_col = -1;
  int       done_en = -1;
  int       done_cols_at = -1;
  int       cyc = 0;
  bit       mon_en = 1'b0;

  function automatic logic [6:0] col_rows(input logic [34:0] f, input int c);
    logic [34:0] s;
    s = f >> (c * NR);
    return ~s[6:0];
  endfunction

  task automatic push_col(input logic [34:0] f, input int c, input int len, input int gap);
    col_exp_t e;
    e.col = c; e.rows = col_rows(f, c); e.len = len; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [34:0] f, input int first_gap);
    for (int c = 0; c < NC; c++) push_col(f, c, CLK_DIV, (c == 0) ? first_gap : BLANK);
  endtask

  // Column monitor: measures each lit column and checks it against the queue.
  initial begin
    logic       prev_en;
    int         lit_len, low_len, rise_gap, cur_col;
    logic [6:0] cur_rows;
    col_exp_t   e;
    prev_en = 1'b0; lit_len = 0; low_len = 0; rise_gap = 0; cur_col = 0; cur_rows = '1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n || !mon_en) begin
        prev_en = 1'b0;
        low_len = 0;
      end else begin
        if (col_en && !prev_en) begin
          cur_col  = int'(col_sel);
          cur_rows = row_data;
          lit_len  = 1;
          rise_gap = low_len;
          low_len  = 0;
          check("col_range", 64'(col_sel < 3'd5), 64'd1);
          if (col_sel == 3'd0) rise0_q.push_back(cyc);
        end else if (col_en) begin
          lit_len++;
          check("row_stable", 64'(row_data), 64'(cur_rows));
        end
        if (!col_en) begin
          check("blank_rows", 64'(row_data), 64'h7F);
          low_len++;
          if (prev_en) begin
            if (exp_q.size() == 0) begin
              check("extra_col", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              check("col_sel", 64'(cur_col), 64'(e.col));
              check("col_rows", 64'(cur_rows), 64'(e.rows));
              check("col_len", 64'(lit_len), 64'(e.len));
              if (e.gap >= 0) check("col_gap", 64'(rise_gap), 64'(e.gap));
            end
            cols_done++;
          end
        end
        if (frame_done) begin
          done_cnt++;
          done_col     = int'(col_sel);
          done_en      = int'(col_en);
          done_cols_at = cols_done;
        end
        prev_en = col_en;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cols(input string tag, input int n, input bit need_en, input int budget);
    int k;
    k = 0;
    while (!(cols_done == n && (!need_en || col_en)) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) check(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt != n && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) check(tag, 64'd0, 64'd1);
  endtask

  task automatic check_start(input string tag, input logic [6:0] rows);
    tick();
    check({tag, "_blank1"}, 64'(col_en), 64'd0);
    tick();
    check({tag, "_blank2"}, 64'(col_en), 64'd0);
    tick();
    check({tag, "_lit"}, 64'(col_en), 64'd1);
    check({tag, "_col0"}, 64'(col_sel), 64'd0);
    check({tag, "_rows"}, 64'(row_data), 64'(rows));
  endtask

  initial begin
    logic [34:0] f1, f2, f3, ones;
    f1   = 35'h1;
    f2   = {7'h33, 7'h00, 7'h7F, 7'h2A, 7'h55};
    f3   = '1;
    ones = '1;

    tick(3);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    check("rst_col_sel", 64'(col_sel), 64'd0);
    check("rst_col_en", 64'(col_en), 64'd0);
    check("rst_rows", 64'(row_data), 64'h7F);
    check("rst_ready", 64'(frame_ready), 64'd1);
    check("rst_done", 64'(frame_done), 64'd0);

    // Reset while column 1 is lit.
    push_col('0, 0, CLK_DIV, -1);
    run = 1'b1;
    wait_cols("t1_timeout", 1, 1'b1, 40);
    tick();
    check("t1_lit_before_rst", 64'(col_en), 64'd1);
    rst_n = 1'b0;
    run   = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t1_col_sel", 64'(col_sel), 64'd0);
    check("t1_col_en", 64'(col_en), 64'd0);
    check("t1_rows", 64'(row_data), 64'h7F);
    check("t1_ready", 64'(frame_ready), 64'd1);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);
    cols_done = 0;
    rise0_q.delete();

    // Load in IDLE, then two frames of free-running scan.
    frame_data = f1;
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
    check("t2_done_pulse", 64'(frame_done), 64'd1);
    check("t2_ready", 64'(frame_ready), 64'd1);
    push_frame(f1, -1);
    push_frame(f1, BLANK);
    run = 1'b1;
    check_start("t2", 7'h7E);
    check("t2_single_done", 64'(done_cnt), 64'd1);

    // Second frame, column 2: load a new frame, then try one that must be ignored.
    wait_cols("t4_timeout", 7, 1'b1, 100);
    check("t4_in_col2", 64'(col_sel), 64'd2);
    check("t3_period", 64'((rise0_q.size() >= 2) ? rise0_q[1] - rise0_q[0] : 0), 64'd30);
    frame_data = f2;
    frame_load = 1'b1;
    tick();
    check("t4_not_ready", 64'(frame_ready), 64'd0);
    frame_data = f3;
    tick();
    frame_load = 1'b0;
    check("t4_still_pending", 64'(frame_ready), 64'd0);
    check("t4_no_early_done", 64'(done_cnt), 64'd1);
    for (int c = 0; c < 3; c++) push_col(f2, c, CLK_DIV, BLANK);
    push_col(f2, 3, 1, BLANK);
    wait_done("t4_done_timeout", 2, 100);
    check("t4_swap_col", 64'(done_col), 64'd0);
    check("t4_swap_col_en", 64'(done_en), 64'd0);
    check("t4_swap_at_wrap", 64'(done_cols_at), 64'd10);
    check("t4_ready_again", 64'(frame_ready), 64'd1);

    // Drop run during column 3.
    wait_cols("t5_timeout", 13, 1'b1, 100);
    check("t5_in_col3", 64'(col_sel), 64'd3);
    run = 1'b0;
    tick();
    check("t5_col_en", 64'(col_en), 64'd0);
    check("t5_col_sel", 64'(col_sel), 64'd0);
    check("t5_rows", 64'(row_data), 64'h7F);
    tick(2);
    check("t5_cols_done", 64'(cols_done), 64'd14);

    // All-ones frame loaded in IDLE, restart from column 0.
    frame_data = ones;
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
    check("t6_done_pulse", 64'(frame_done), 64'd1);
    push_frame(ones, -1);
    run = 1'b1;
    check_start("t6", 7'h00);
    wait_cols("t6_timeout", 19, 1'b0, 100);
    run = 1'b0;
    tick(3);
    check("end_q_empty", 64'(exp_q.size()), 64'd0);
    check("end_done_cnt", 64'(done_cnt), 64'd3);
    check("end_col_en", 64'(col_en), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
